// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM state encoding and abort data.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [15:0] MEM_ABORT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// WAIT-cycle counter; expired fires on the increment that reaches TIMEOUT.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = inc & ((cnt_q + 8'd1) == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller with pipeline stall and done pulse.
// Optional WAIT timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be within 1..255");
    end

    mem_state_e  state_q;
    mem_state_e  state_d;
    logic        req;
    logic        accept;
    logic        timeout_hit;
    logic        complete;
    logic        mem_wr_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic [15:0] rdata_q;

    assign req    = MemRead | MemWrite;
    assign accept = (state_q == IDLE) & req;

`ifdef MEM_TIMEOUT_EN
    logic expired;
    logic err_q;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state_q == REQ) & ~mem_valid),
        .inc     (state_q == WAIT),
        .expired (expired)
    );

    assign timeout_hit = (state_q == WAIT) & ~mem_valid & expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = REQ;
            REQ:  state_d = mem_valid ? DONE : WAIT;
            WAIT: if (mem_valid | timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset must drop stall even though the IDLE term follows req directly.
    always_comb begin
        mem_en = (state_q == REQ);
        done   = (state_q == DONE);
        stall  = rst_n & (accept | (state_q == REQ) | (state_q == WAIT));
    end

    assign complete = ((state_q == REQ) & mem_valid)
                    | ((state_q == WAIT) & (mem_valid | timeout_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept) begin
            mem_wr_q    <= MemWrite;
            mem_addr_q  <= {addr[15:1], 1'b0};
            mem_wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (complete & ~mem_wr_q) begin
            rdata_q <= mem_valid ? mem_rdata : MEM_ABORT_DATA;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before abort (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port MemRead, input, 1, the load request from instruction decode.
REQ-005 The block SHALL have port MemWrite, input, 1, the store request from instruction decode.
REQ-006 The block SHALL have ports addr, input, 16, the byte address, and wdata, input, 16, the store data.
REQ-007 The block SHALL have port mem_rdata, input, 16, the memory read data, and port mem_valid, input, 1, the memory completion strobe.
REQ-008 The block SHALL have port mem_en, output, 1, the memory request strobe, and port mem_wr, output, 1, which is 1 for write and 0 for read.
REQ-009 The block SHALL have ports mem_addr, output, 16, and mem_wdata, output, 16, both registered.
REQ-010 The block SHALL have port rdata, output, 16, the load result, and port done, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port stall, output, 1, the pipeline freeze, and port err, output, 1, a sticky timeout flag.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-013 The request condition is req = MemRead | MemWrite; in IDLE, req=1 SHALL capture addr, wdata and direction at the edge and move the FSM to REQ.
REQ-014 When MemRead and MemWrite are both 1, the request SHALL be treated as a write.
REQ-015 mem_addr SHALL equal {addr[15:1],1'b0} (word aligned); addr[0] is ignored.
REQ-016 In REQ, mem_en SHALL be 1 for exactly one cycle; mem_en SHALL be 0 in all other states.
REQ-017 REQ SHALL go to DONE if mem_valid=1 in the same cycle, and SHALL go to WAIT otherwise.
REQ-018 WAIT SHALL go to DONE on mem_valid=1.
REQ-019 On a read, rdata SHALL load mem_rdata on the completing edge and hold it until the next read completes.
REQ-020 stall SHALL equal (state==IDLE & req) | state==REQ | state==WAIT, which is combinational on req; stall SHALL be 0 in DONE.
REQ-021 done SHALL be 1 only in DONE; DONE SHALL always return to IDLE, and a req present in the DONE cycle SHALL NOT be accepted until the following IDLE cycle.
REQ-022 mem_valid SHALL be ignored in IDLE and DONE.
REQ-023 mem_addr, mem_wdata and mem_wr SHALL stay stable from REQ through the completing cycle.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0 and the timeout counter to 0.
REQ-025 While rst_n=0, stall SHALL be 0.
REQ-026 Reset in REQ or WAIT SHALL abandon the access without any done pulse; a mem_valid arriving after reset deassertion SHALL be ignored.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 With MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT without mem_valid, the FSM SHALL go to DONE, set err=1 (sticky until reset) and load rdata=16'hDEAD on a read.
REQ-029 Without MEM_TIMEOUT_EN, the counter logic SHALL be absent, err SHALL be tied to 0, and WAIT SHALL last indefinitely.

Structure
REQ-030 The state enum (2-bit encoding IDLE=0, REQ=1, WAIT=2, DONE=3) and the constant MEM_ABORT_DATA=16'hDEAD SHALL reside in the shared package cpu_pkg.
REQ-031 The timeout counter SHALL be one sub-module, mem_timeout_cnt (inputs clr, inc; output expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-032 The bench SHALL apply a read to addr=16'h0011 with mem_rdata=16'hBEEF and mem_valid 3 cycles after mem_en, and SHALL check mem_addr=16'h0010, stall=1 for 5 cycles, done for one cycle, and rdata=16'hBEEF.
REQ-033 The bench SHALL apply a write of wdata=16'h1234 with mem_valid in the REQ cycle, and SHALL check mem_wr=1, mem_wdata=16'h1234, done on the next cycle, and rdata unchanged.
REQ-034 The bench SHALL apply MemRead=MemWrite=1 and SHALL check mem_wr=1.
REQ-035 The bench SHALL hold req through DONE back-to-back and SHALL check that the second mem_en comes 2 cycles after done.
REQ-036 The bench SHALL pulse rst_n low in WAIT, then apply mem_valid, and SHALL check state=IDLE, no done and stall=0.
REQ-037 With MEM_TIMEOUT_EN and TIMEOUT=4, the bench SHALL never assert mem_valid and SHALL check that done asserts after 4 WAIT cycles, err=1 and rdata=16'hDEAD; with the macro undefined it SHALL check that stall persists 100 cycles.
